clique_scan_ctrl: RTL and testbench
===================================

CLIQUE_SCAN_CTRL -- requirements
Module: clique_scan_ctrl

Interface
REQ-001 The block SHALL provide parameter N, default 8, the number of graph vertices (legal range 3..16).
REQ-002 The block SHALL provide parameter K, default 3, the clique size searched (legal range 2..N).
REQ-003 The block SHALL provide parameter CW, default 8, the width of the clique counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a scan; sampled only in IDLE.
REQ-007 adj  input  N*N  adjacency matrix; bit i*N+j set means edge i->j.
REQ-008 busy  output  1  high in CHECK, EMIT and NEXT.
REQ-009 done  output  1  one-cycle pulse marking scan completion.
REQ-010 clq_valid  output  1  a found clique is presented.
REQ-011 clq_ready  input  1  the consumer accepts the presented clique.
REQ-012 clq_mask  output  N  vertex bitmask of the presented clique (bit v set = vertex v in the clique).
REQ-013 clq_count  output  CW  number of cliques accepted in the current or last scan.

Function
REQ-014 The FSM SHALL have the states IDLE, CHECK, EMIT, NEXT and DONE.
REQ-015 On a rising edge with start=1 in IDLE, the block SHALL:
- snapshot adj into an internal register;
- load the subset indices idx[0..K-1] with 0..K-1;
- set the pair pointer to (0,1);
- clear clq_count;
- enter CHECK.
REQ-016 Changes on adj after the start edge SHALL have no effect until the next start.
REQ-017 CHECK SHALL test one pair (p,q), p<q, per cycle. The edge is present only if both snapshot bits idx[p]*N+idx[q] and idx[q]*N+idx[p] are 1.
REQ-018 Diagonal bits (i*N+i) SHALL be ignored.
REQ-019 In CHECK, a missing edge SHALL cause a transition to NEXT on the same edge (early abort).
REQ-020 In CHECK, a present edge on a pair that is not the last SHALL advance the pair pointer in order (0,1),(0,2),...,(0,K-1),(1,2),...,(K-2,K-1).
REQ-021 A present edge on the last pair SHALL cause a transition to EMIT.
REQ-022 In EMIT, clq_valid SHALL be 1 and clq_mask SHALL be the OR of the one-hot vectors of idx[0..K-1]. Both SHALL hold stable until clq_valid and clq_ready are sampled together.
REQ-023 On the accepting edge, clq_count SHALL increment, saturating at 2^CW-1, and the FSM SHALL enter NEXT.
REQ-024 clq_valid SHALL be 0 in every state other than EMIT.
REQ-025 NEXT SHALL advance idx to the next K-combination in lexicographic order and reset the pair pointer to (0,1).
- If idx[0] was N-K (last combination), NEXT SHALL go to DONE instead.
- Otherwise NEXT SHALL go to CHECK.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 clq_count SHALL hold its final value until the next accepted start.
REQ-028 start SHALL be ignored outside IDLE. It is not queued.
REQ-029 Per-subset latency SHALL be:
- (pairs tested) + 1 cycle for a rejected subset;
- C(K,2) + (EMIT cycles) + 1 for an accepted subset, where EMIT lasts at least 1 cycle.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from start or adj.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE and busy, done, clq_valid, clq_mask and clq_count SHALL all be 0. This takes effect immediately and independently of clk.
REQ-032 Reset asserted mid-scan SHALL discard the scan: no done pulse, with clq_valid deasserting asynchronously.
REQ-033 After release, the block SHALL accept start on the first rising edge.

Verification
REQ-034 N=4, K=3, complete graph, clq_ready tied 1: masks 0x7, 0xB, 0xD, 0xE in order; clq_count=4; done high in the 21st cycle after the start edge.
REQ-035 N=4, K=3, adj=0: no clq_valid; clq_count=0; done high in the 9th cycle after the start edge.
REQ-036 N=4, K=3, edges 0-1, 1-2, 0-2 only (symmetric): single mask 0x7. Then hold clq_ready=0 for 5 cycles: clq_valid and mask stay stable, busy=1, count stays 0 until acceptance, then becomes 1.
REQ-037 N=4, K=3, complete graph except the bit for 3->2 cleared (asymmetric): only masks 0x7 and 0xB; count=2.
REQ-038 Start pulsed again at cycle 5 of a scan, with adj changed at cycle 3: no effect on the running scan. Then rst_n pulsed low during EMIT: clq_valid drops immediately, count=0, no done; a new start then completes normally.

Source files
------------

// File: rtl/clique_scan_ctrl.sv
// Exhaustive K-clique scanner: walks every K-subset of an N-vertex graph in
// lexicographic order, checks all pairs, and streams each clique's mask.
//
//   state | meaning
//   IDLE  | waiting for start
//   CHECK | testing one vertex pair of the current subset
//   EMIT  | presenting a clique, waiting for clq_ready
//   NEXT  | stepping to the next K-combination
//   DONE  | one-cycle completion pulse
`timescale 1ns/1ps
module clique_scan_ctrl #(
    parameter int N  = 8,
    parameter int K  = 3,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N-1:0]   adj,
    output logic             busy,
    output logic             done,
    output logic             clq_valid,
    input  logic             clq_ready,
    output logic [N-1:0]     clq_mask,
    output logic [CW-1:0]    clq_count
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(K);
    localparam int AW = $clog2(N*N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        EMIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [N*N-1:0]    adj_snap;
    logic [IW-1:0]     idx     [K];
    logic [IW-1:0]     idx_nxt [K];
    logic [PW-1:0]     p, q;
    logic [PW-1:0]     piv;
    logic [AW-1:0]     bit_pq, bit_qp;
    logic              edge_ok, last_pair, last_comb;

    // Subset indices are strictly increasing, so p<q never hits a diagonal bit.
    always_comb begin
        bit_pq    = AW'(idx[p]) * AW'(N) + AW'(idx[q]);
        bit_qp    = AW'(idx[q]) * AW'(N) + AW'(idx[p]);
        edge_ok   = adj_snap[bit_pq] & adj_snap[bit_qp];
        last_pair = (p == PW'(K-2)) && (q == PW'(K-1));
        last_comb = (int'(idx[0]) == N-K);
    end

    // Next combination: bump the rightmost index that still has room, then
    // pack everything to its right immediately after it.
    always_comb begin
        piv = '0;
        for (int i = 0; i < K; i++) begin
            idx_nxt[i] = idx[i];
            if (int'(idx[i]) < N-K+i)
                piv = PW'(i);
        end
        idx_nxt[piv] = idx[piv] + IW'(1);
        for (int j = 0; j < K; j++) begin
            if (j > int'(piv))
                idx_nxt[j] = IW'(int'(idx[piv]) + 1 + j - int'(piv));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK: begin
                if (!edge_ok)
                    state_nxt = NEXT;
                else if (last_pair)
                    state_nxt = EMIT;
            end
            EMIT:    if (clq_ready) state_nxt = NEXT;
            NEXT:    state_nxt = last_comb ? DONE : CHECK;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_snap  <= '0;
            p         <= '0;
            q         <= PW'(1);
            clq_count <= '0;
            for (int i = 0; i < K; i++)
                idx[i] <= IW'(i);
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        adj_snap  <= adj;
                        p         <= '0;
                        q         <= PW'(1);
                        clq_count <= '0;
                        for (int i = 0; i < K; i++)
                            idx[i] <= IW'(i);
                    end
                end
                CHECK: begin
                    if (edge_ok && !last_pair) begin
                        if (q == PW'(K-1)) begin
                            p <= p + PW'(1);
                            q <= p + PW'(2);
                        end else begin
                            q <= q + PW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (clq_ready && (clq_count != {CW{1'b1}}))
                        clq_count <= clq_count + CW'(1);
                end
                NEXT: begin
                    p <= '0;
                    q <= PW'(1);
                    for (int i = 0; i < K; i++)
                        idx[i] <= idx_nxt[i];
                end
                default: ;
            endcase
        end
    end

    // Mask is gated by state so that reset clears it asynchronously.
    always_comb begin
        clq_mask = '0;
        if (state == EMIT)
            for (int i = 0; i < K; i++)
                clq_mask[idx[i]] = 1'b1;
    end

    assign busy      = (state == CHECK) || (state == EMIT) || (state == NEXT);
    assign done      = (state == DONE);
    assign clq_valid = (state == EMIT);

endmodule

// File: tb/tb_clique_scan_ctrl.sv
// Directed bench for clique_scan_ctrl with N=4, K=3.
`timescale 1ns/1ps
module tb_clique_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] adj;
    logic        busy;
    logic        done;
    logic        clq_valid;
    logic        clq_ready;
    logic [3:0]  clq_mask;
    logic [7:0]  clq_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] got [8];
    int         n_got;
    int         done_cyc;
    int         n_done;
    int         nd;
    bit         found;

    clique_scan_ctrl #(.N(4), .K(3), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .adj       (adj),
        .busy      (busy),
        .done      (done),
        .clq_valid (clq_valid),
        .clq_ready (clq_ready),
        .clq_mask  (clq_mask),
        .clq_count (clq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs ncyc cycles after the start edge, logging accepted masks and done.
    task automatic collect(input int ncyc, input bit disturb);
        n_got    = 0;
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (disturb && c == 3) adj = 16'h0000;
            start = disturb && (c == 5);
            if (clq_valid && clq_ready && n_got < 8) begin
                got[n_got] = clq_mask;
                n_got++;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        adj       = 16'h0000;
        clq_ready = 1'b1;
        #12;
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_valid", clq_valid, 0);
        chk("rst_mask",  clq_mask,  0);
        chk("rst_count", clq_count, 0);
        tick();
        rst_n = 1'b1;

        // complete graph (diagonal bits set too), always ready
        adj = 16'hFFFF;
        do_start();
        chk("full_busy", busy, 1);
        collect(25, 1'b0);
        chk("full_ncl",  n_got, 4);
        chk("full_m0",   got[0], 4'h7);
        chk("full_m1",   got[1], 4'hB);
        chk("full_m2",   got[2], 4'hD);
        chk("full_m3",   got[3], 4'hE);
        chk("full_done", done_cyc, 21);
        chk("full_cnt",  clq_count, 4);

        // empty graph
        adj = 16'h0000;
        do_start();
        collect(15, 1'b0);
        chk("empty_ncl",  n_got, 0);
        chk("empty_done", done_cyc, 9);
        chk("empty_cnt",  clq_count, 0);

        // triangle 0-1-2 with backpressure on the single clique
        adj       = 16'h0356;
        clq_ready = 1'b0;
        do_start();
        found = 1'b0;
        for (int c = 1; c <= 10 && !found; c++) begin
            if (clq_valid) found = 1'b1;
            else tick();
        end
        chk("tri_valid", clq_valid, 1);
        chk("tri_mask",  clq_mask, 4'h7);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("tri_hold_valid", clq_valid, 1);
            chk("tri_hold_mask",  clq_mask, 4'h7);
            chk("tri_hold_busy",  busy, 1);
            chk("tri_hold_cnt",   clq_count, 0);
        end
        clq_ready = 1'b1;
        tick();
        chk("tri_acc_cnt",   clq_count, 1);
        chk("tri_acc_valid", clq_valid, 0);
        collect(20, 1'b0);
        chk("tri_more",  n_got, 0);
        chk("tri_ndone", n_done, 1);
        chk("tri_cnt",   clq_count, 1);

        // only the 3->2 direction missing
        adj = 16'h3BDE;
        do_start();
        collect(25, 1'b0);
        chk("asym_ncl", n_got, 2);
        chk("asym_m0",  got[0], 4'h7);
        chk("asym_m1",  got[1], 4'hB);
        chk("asym_cnt", clq_count, 2);

        // adj change and extra start during a scan
        adj = 16'h7BDE;
        do_start();
        collect(25, 1'b1);
        chk("dist_ncl",   n_got, 4);
        chk("dist_m3",    got[3], 4'hE);
        chk("dist_done",  done_cyc, 21);
        chk("dist_ndone", n_done, 1);
        chk("dist_cnt",   clq_count, 4);

        // reset during the second EMIT
        adj = 16'hFFFF;
        do_start();
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            if (clq_valid && clq_count == 8'd1) found = 1'b1;
            else tick();
        end
        chk("mid_emit", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", clq_valid, 0);
        chk("mid_cnt",   clq_count, 0);
        chk("mid_busy",  busy, 0);
        chk("mid_mask",  clq_mask, 0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("mid_nodone", nd, 0);
        do_start();
        chk("post_busy", busy, 1);
        collect(25, 1'b0);
        chk("post_ncl",  n_got, 4);
        chk("post_done", done_cyc, 21);
        chk("post_cnt",  clq_count, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
